// File: rtl/seven_seg_scanner_pkg.sv
// Shared types and constants for the seven-segment scanner and its BCD converter.
package seven_seg_scanner_pkg;
  localparam int NUM_DIGITS = 4;
  localparam int BIN_W      = 14;
  localparam int BCD_W      = 4 * NUM_DIGITS;
  localparam logic [BIN_W-1:0] BCD_MAX = 14'd9999;
  localparam logic [NUM_DIGITS-1:0] AN_IDLE = 4'b1111;

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_e;

  // Double-dabble correction: any nibble >= 5 gets +3 before the shift.
  function automatic logic [BCD_W-1:0] dabble_adj(input logic [BCD_W-1:0] b);
    logic [BCD_W-1:0] r;
    r = b;
    for (int n = 0; n < NUM_DIGITS; n++)
      if (b[n*4 +: 4] >= 4'd5) r[n*4 +: 4] = b[n*4 +: 4] + 4'd3;
    return r;
  endfunction
endpackage

// File: rtl/seven_seg_scanner_bin_to_bcd_seq.sv
// Sequential 14-bit binary to 4-digit BCD converter (one shift per cycle, 14 shifts).
module bin_to_bcd_seq
  import seven_seg_scanner_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [BIN_W-1:0] bin_i,
  output logic [BCD_W-1:0] bcd_o,
  output logic             done_o,
  output logic             busy_o
);
  state_e           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [BIN_W-1:0] bin_q, bin_d;
  logic [BCD_W-1:0] bcd_q, bcd_d;
  logic [BCD_W-1:0] adj;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bin_q   <= '0;
      bcd_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    adj     = dabble_adj(bcd_q);
    case (state_q)
      IDLE: if (start_i) begin
        bin_d   = bin_i;
        bcd_d   = '0;
        cnt_d   = '0;
        state_d = SHIFT;
      end
      SHIFT: begin
        {bcd_d, bin_d} = {adj[BCD_W-2:0], bin_q, 1'b0};
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'(BIN_W - 1)) state_d = COMMIT;
      end
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bcd_o  = bcd_q;
  assign done_o = (state_q == COMMIT);
  assign busy_o = (state_q != IDLE);
endmodule

// File: rtl/seven_seg_scanner.sv
// Four-digit multiplexed seven-segment scanner fed by a sequential binary-to-BCD converter.
// Optional build macro LEADING_ZERO_BLANK_EN blanks slots above the most significant non-zero digit.
module seven_seg_scanner
  import seven_seg_scanner_pkg::*;
#(
  parameter int REFRESH_DIV = 50000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [BIN_W-1:0]      bin_in,
  output logic                  busy,
  output logic                  ovf,
  output logic [3:0]            digit_val,
  output logic [NUM_DIGITS-1:0] digit_an
);
  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  logic             conv_busy, conv_done, accept;
  logic [BIN_W-1:0] clamp;
  logic [BCD_W-1:0] bcd;

  logic                           ovf_q, ovf_d;
  logic [NUM_DIGITS-1:0][3:0]     disp_q, disp_d;
  logic [CNT_W-1:0]               cnt_q, cnt_d;
  logic [1:0]                     idx_q, idx_d;
  logic [NUM_DIGITS-1:0]          an_q, an_d;
  logic [3:0]                     val_q, val_d;
  logic                           wrap;

  // COMMIT still reports busy, so a load in the returning cycle is dropped.
  assign accept = load & ~conv_busy;
  assign clamp  = (bin_in > BCD_MAX) ? BCD_MAX : bin_in;

  bin_to_bcd_seq u_conv (
    .clk     (clk),
    .rst     (rst),
    .start_i (accept),
    .bin_i   (clamp),
    .bcd_o   (bcd),
    .done_o  (conv_done),
    .busy_o  (conv_busy)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf_q  <= 1'b0;
      disp_q <= '0;
      cnt_q  <= '0;
      idx_q  <= '0;
      an_q   <= 4'b1110;
      val_q  <= '0;
    end else begin
      ovf_q  <= ovf_d;
      disp_q <= disp_d;
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      an_q   <= an_d;
      val_q  <= val_d;
    end
  end

  assign wrap = (cnt_q == CNT_W'(REFRESH_DIV - 1));

`ifdef LEADING_ZERO_BLANK_EN
  logic [1:0] msd;
`endif

  always_comb begin
    ovf_d  = accept ? (bin_in > BCD_MAX) : ovf_q;
    disp_d = conv_done ? bcd : disp_q;
    cnt_d  = wrap ? '0 : cnt_q + 1'b1;
    idx_d  = wrap ? idx_q + 2'd1 : idx_q;
    // Anode and digit follow the next index so both switch on the slot-advance edge.
    an_d   = ~(4'b0001 << idx_d);
    val_d  = disp_q[idx_d];
`ifdef LEADING_ZERO_BLANK_EN
    msd = '0;
    for (int i = 1; i < NUM_DIGITS; i++)
      if (disp_q[i] != 4'd0) msd = 2'(i);
    if (idx_d > msd) an_d = AN_IDLE;
`endif
  end

  assign busy      = conv_busy;
  assign ovf       = ovf_q;
  assign digit_an  = an_q;
  assign digit_val = val_q;
endmodule

// File: tb/tb_seven_seg_scanner.sv
// Self-checking bench for seven_seg_scanner with REFRESH_DIV=4 and a cycle-level reference model.
module tb_seven_seg_scanner;
  localparam int DIV = 4;

  logic        clk = 1'b0, rst = 1'b0, load = 1'b0;
  logic [13:0] bin_in = '0;
  logic        busy, ovf;
  logic [3:0]  digit_val, digit_an;

  always #5 clk = ~clk;

  seven_seg_scanner #(.REFRESH_DIV(DIV)) dut (
    .clk(clk), .rst(rst), .load(load), .bin_in(bin_in),
    .busy(busy), .ovf(ovf), .digit_val(digit_val), .digit_an(digit_an)
  );

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int dig(input int v, input int i);
    return (v / (10 ** i)) % 10;
  endfunction

  // Inputs as the DUT saw them at the last rising edge.
  logic        load_s = 1'b0, rst_s = 1'b0;
  logic [13:0] bin_s = '0;
  initial forever begin
    @(posedge clk);
    load_s = load; bin_s = bin_in; rst_s = rst;
  end

  // Model: k = rising edges since reset release; a load accepted at edge e
  // holds busy through edge e+14, commits at e+15, shows from e+16.
  int k, last, pend, disp_m, ovf_m, idx, msd;
  logic [3:0] exp_an, exp_val;
  logic       exp_busy;
  initial begin
    k = 0; last = -100; pend = 0; disp_m = 0; ovf_m = 0;
    exp_an = 4'b1110; exp_val = 0; exp_busy = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        k = 0; last = -100; disp_m = 0; ovf_m = 0;
        exp_an = 4'b1110; exp_val = 0; exp_busy = 0;
      end else if (rst_s) begin
        k++;
        idx = (k / DIV) % 4;
        exp_val = 4'(dig(disp_m, idx));
        exp_an = ~(4'b0001 << idx);
`ifdef LEADING_ZERO_BLANK_EN
        msd = 0;
        for (int i = 1; i < 4; i++) if (dig(disp_m, i) != 0) msd = i;
        if (idx > msd) exp_an = 4'b1111;
`endif
        if (k == last + 15) disp_m = pend;
        if (load_s && k >= last + 16) begin
          last = k;
          pend = (bin_s > 14'd9999) ? 9999 : int'(bin_s);
          ovf_m = (bin_s > 14'd9999) ? 1 : 0;
        end
        exp_busy = (k - last >= 0) && (k - last <= 14);
      end
      chk("busy", busy, exp_busy);
      chk("ovf", ovf, ovf_m);
      chk("digit_an", digit_an, exp_an);
      chk("digit_val", digit_val, exp_val);
      chk("an_onehot", ($countones(~digit_an) <= 1), 1);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load_one(input int v);
    bin_in = 14'(v); load = 1'b1;
    cyc(1);
    load = 1'b0;
  endtask

  // Observe one full rotation and compare each visible slot to literal digits.
  task automatic check_slots(input string nm, input int d0, input int d1, input int d2, input int d3);
    int exp_d[4];
    int got[4];
    logic [3:0] seen;
    int blanks, hi, show;
    exp_d = '{d0, d1, d2, d3};
    got = '{0, 0, 0, 0};
    seen = '0; blanks = 0; hi = 0;
    for (int i = 1; i < 4; i++) if (exp_d[i] != 0) hi = i;
    repeat (8 * DIV) begin
      @(negedge clk);
      case (digit_an)
        4'b1110: begin seen[0] = 1'b1; got[0] = int'(digit_val); end
        4'b1101: begin seen[1] = 1'b1; got[1] = int'(digit_val); end
        4'b1011: begin seen[2] = 1'b1; got[2] = int'(digit_val); end
        4'b0111: begin seen[3] = 1'b1; got[3] = int'(digit_val); end
        4'b1111: blanks++;
        default: ;
      endcase
    end
    for (int i = 0; i < 4; i++) begin
`ifdef LEADING_ZERO_BLANK_EN
      show = (i <= hi) ? 1 : 0;
`else
      show = 1;
`endif
      chk({nm, "_seen"}, seen[i], show);
      if (seen[i]) chk({nm, "_slot"}, got[i], exp_d[i]);
    end
`ifdef LEADING_ZERO_BLANK_EN
    chk({nm, "_blank"}, (blanks > 0), (hi < 3));
`else
    chk({nm, "_blank"}, (blanks > 0), 0);
`endif
    @(posedge clk); #1;
  endtask

  initial begin
    cyc(3);
    rst = 1'b1;
    cyc(20);
    check_slots("rst_idle", 0, 0, 0, 0);
    chk("rst_busy", busy, 0);

    load_one(1234);
    chk("busy_start", busy, 1);
    cyc(14);
    chk("busy_last", busy, 1);
    cyc(1);
    chk("busy_end", busy, 0);
    cyc(10);
    check_slots("v1234", 4, 3, 2, 1);
    chk("v1234_ovf", ovf, 0);
    chk("model_1234", disp_m, 1234);

    load_one(16383);
    cyc(20);
    check_slots("v16383", 9, 9, 9, 9);
    chk("v16383_ovf", ovf, 1);
    load_one(5);
    cyc(20);
    check_slots("v5", 5, 0, 0, 0);
    chk("v5_ovf", ovf, 0);

    bin_in = 14'd1234; load = 1'b1;
    cyc(1);
    bin_in = 14'd42;
    cyc(10);
    load = 1'b0;
    cyc(10);
    check_slots("ignore", 4, 3, 2, 1);

    // Held load: dropped during COMMIT, taken the cycle after.
    bin_in = 14'd100; load = 1'b1;
    cyc(1);
    bin_in = 14'd200;
    cyc(15);
    chk("commit_drop_busy", busy, 0);
    cyc(1);
    chk("reaccept_busy", busy, 1);
    load = 1'b0;
    cyc(20);
    check_slots("v200", 0, 0, 2, 0);
    chk("model_200", disp_m, 200);

    load_one(42);
    cyc(20);
    check_slots("v42", 2, 4, 0, 0);

    load_one(7777);
    cyc(7);
    rst = 1'b0;
    cyc(2);
    rst = 1'b1;
    cyc(30);
    check_slots("abort", 0, 0, 0, 0);
    chk("abort_busy", busy, 0);
    chk("abort_ovf", ovf, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/seven_seg_scanner.md
SEVEN_SEG_SCANNER -- requirements
Module: seven_seg_scanner

Interface
REQ-001 The block SHALL have parameter REFRESH_DIV, default 50000, giving the clock cycles each digit stays lit (legal range 2..2^20).
REQ-002 The block SHALL have port clk, input, 1 bit: single rising-edge clock.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port load, input, 1 bit: request to convert bin_in.
REQ-005 The block SHALL have port bin_in, input, 14 bits: unsigned binary value to display.
REQ-006 The block SHALL have port busy, output, 1 bit: conversion in progress; load is ignored while it is high.
REQ-007 The block SHALL have port ovf, output, 1 bit: the last accepted value exceeded 9999.
REQ-008 The block SHALL have port digit_val, output, 4 bits: BCD digit for the current slot, which feeds the 4-bit BCD-to-7-segment converter.
REQ-009 The block SHALL have port digit_an, output, 4 bits: active-low anode enables; bit i lights digit i, and digit 0 is the units digit.

Function
REQ-010 The FSM SHALL have states IDLE, SHIFT and COMMIT; reset enters IDLE.
REQ-011 In IDLE with load=1, the block SHALL capture min(bin_in, 9999), set ovf = (bin_in > 9999), and go to SHIFT; busy SHALL be 1 from the next cycle.
REQ-012 SHIFT SHALL run exactly 14 cycles of shift-and-add-3 (double-dabble), with add-3 applied to any nibble >= 5 before each shift.
REQ-013 COMMIT SHALL last 1 cycle: the four BCD digits are written to the display register, then the FSM returns to IDLE with busy=0.
REQ-014 The new digits SHALL appear on digit_val 16 cycles after the load edge, at the first slot that shows them; busy SHALL be high for exactly 15 cycles.
REQ-015 load SHALL be ignored while busy=1, and the in-flight conversion SHALL be unaffected.
REQ-016 load asserted in the same cycle that COMMIT returns to IDLE SHALL be ignored; it is accepted on the following cycle if still held.
REQ-017 The display register SHALL change only in COMMIT, so no partial BCD result is ever displayed.
REQ-018 The refresh counter SHALL count 0..REFRESH_DIV-1 and wrap; on wrap, the slot index (2 bits) SHALL advance 0->1->2->3->0.
REQ-019 digit_an SHALL be registered and equal ~(4'b0001 << index); digit_val SHALL be registered and equal display digit[index], with both changing on the same edge.
REQ-020 At most one digit_an bit SHALL be low at any time.

Reset
REQ-021 On rst=0, all state SHALL clear asynchronously: FSM=IDLE, busy=0, ovf=0, display digits=0, refresh counter=0, index=0, digit_an=4'b1110, digit_val=0.
REQ-022 Reset asserted mid-conversion SHALL abort the conversion, and no partial value SHALL ever be committed.
REQ-023 The first slot advance after reset release SHALL occur REFRESH_DIV cycles after the first active clock edge.

Configuration
REQ-024 With macro LEADING_ZERO_BLANK_EN defined, every slot above the most significant non-zero digit SHALL drive digit_an=4'b1111; the units digit SHALL never be blanked, so value 0 shows a single "0".
REQ-025 Without LEADING_ZERO_BLANK_EN, all four digits SHALL always be driven, including leading zeros.
REQ-026 Timing of the refresh counter and slot index SHALL be identical in both builds.

Structure
REQ-027 A shared package SHALL hold the FSM state enum, NUM_DIGITS=4, BIN_W=14, the BCD max constant 9999, and the anode idle value 4'b1111.
REQ-028 The double-dabble datapath SHALL be a sub-module bin_to_bcd_seq (start, bin in, 16-bit BCD out, done); the scan logic SHALL stay in the top level.

Verification (REFRESH_DIV=4 in all scenarios)
REQ-029 Reset release, no load -> digit_an cycles 1110, 1101, 1011, 0111, 4 cycles each; digit_val=0 throughout; busy=0.
REQ-030 load=1 for one cycle with bin_in=1234 -> busy high 15 cycles; from cycle 16, the slot 0..3 digits read 4, 3, 2, 1; ovf=0.
REQ-031 bin_in=16383 -> digits read 9, 9, 9, 9 and ovf=1; a following load of 5 -> ovf=0 and digits read 5, 0, 0, 0.
REQ-032 Load 1234, then load=1 with bin_in=42 held for 10 cycles -> the second request is ignored and the display shows 1234.
REQ-033 Load 0042 with LEADING_ZERO_BLANK_EN -> slots 2 and 3 drive digit_an=1111; without the macro, they drive 1011 and 0111 with digit_val=0.
REQ-034 Load 7777, then rst=0 at cycle 8 -> the display stays 0000 and busy=0 after reset release.
